// File: rtl/dcache_store_port_responder_if.sv
// Store-unit <-> dcache request port: request/address/data from the store unit,
// grant and read response from the dcache responder.
interface dcache_store_port_responder_if #(
  parameter int INDEX_W = 12,
  parameter int TAG_W   = 22
);
  logic               data_req;
  logic               data_we;
  logic [INDEX_W-1:0] address_index;
  logic [TAG_W-1:0]   address_tag;
  logic               tag_valid;
  logic [31:0]        data_wdata;
  logic [3:0]         data_be;
  logic [1:0]         data_size;
  logic               kill_req;
  logic               data_gnt;
  logic               data_rvalid;
  logic [31:0]        data_rdata;

  modport master (
    output data_req, data_we, address_index, address_tag, tag_valid,
           data_wdata, data_be, data_size, kill_req,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_we, address_index, address_tag, tag_valid,
           data_wdata, data_be, data_size, kill_req,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/dcache_store_port_responder.sv
// Dcache-side responder for the store unit's request port: grants after a
// configurable latency, commits byte-enabled stores and answers word reads.
module dcache_store_port_responder #(
  parameter  int GNT_LATENCY = 1,
  parameter  int DEPTH       = 16,
  parameter  int INDEX_W     = 12,
  parameter  int TAG_W       = 22,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  dcache_store_port_responder_if.slave    req_port,
  input  logic                            stall_i,
  input  logic [AW-1:0]                   dbg_addr_i,
  output logic [31:0]                     dbg_rdata_o,
  output logic [7:0]                      store_count_o,
  output logic                            busy_o,
  output logic                            protocol_err_o
);

  localparam logic [2:0] CNT_LAT  = 3'(GNT_LATENCY);
  localparam bit         COMB_GNT = (GNT_LATENCY == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [7:0]         count_q, count_d;
  logic               err_q, err_d;
  logic [31:0]        mem_q [DEPTH];

  logic [INDEX_W-1:0]       index_sel;
  logic [TAG_W-1:0]         tag_sel;
  logic [TAG_W+INDEX_W-1:0] paddr;
  logic [AW-1:0]            wa;
  logic                     gnt, rvalid, commit_st;

  // In WAIT the index comes from the copy taken on entry; a fresh tag always wins.
  assign index_sel = (state_q == S_WAIT) ? index_q : req_port.address_index;
  assign tag_sel   = req_port.tag_valid ? req_port.address_tag : tag_q;
  assign paddr     = {tag_sel, index_sel};
  assign wa        = paddr[AW+1:2];

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    index_d = index_q;
    tag_d   = tag_q;
    err_d   = err_q;
    gnt     = 1'b0;
    rvalid  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_port.data_req) begin
          if (COMB_GNT && !stall_i) begin
            gnt = 1'b1;
            if (!req_port.data_we) state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 3'd1;
            index_d = req_port.address_index;
            tag_d   = tag_sel;
          end
        end
      end
      S_WAIT: begin
        tag_d = tag_sel;
        if (req_port.kill_req) begin
          state_d = S_IDLE;
        end else if (!req_port.data_req) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q >= CNT_LAT && !stall_i) begin
          gnt     = 1'b1;
          state_d = req_port.data_we ? S_IDLE : S_RESP;
        end else begin
          cnt_d = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
        end
      end
      S_RESP: begin
        rvalid  = !req_port.kill_req;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign commit_st = gnt && req_port.data_req && req_port.data_we;
  assign rdata_d   = (gnt && !req_port.data_we) ? mem_q[wa] : rdata_q;
  assign count_d   = commit_st ? count_q + 8'd1 : count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      index_q <= '0;
      tag_q   <= '0;
      rdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      index_q <= index_d;
      tag_q   <= tag_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the backing store is tiny and must read as zero after every reset,
  // so it is built from resettable flops rather than an inferred RAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (commit_st) begin
      for (int b = 0; b < 4; b++) begin
        if (req_port.data_be[b]) mem_q[wa][8*b +: 8] <= req_port.data_wdata[8*b +: 8];
      end
    end
  end

  assign req_port.data_gnt    = gnt;
  assign req_port.data_rvalid = rvalid;
  assign req_port.data_rdata  = (state_q == S_RESP) ? rdata_q : '0;

  assign dbg_rdata_o    = mem_q[dbg_addr_i];
  assign store_count_o  = count_q;
  assign busy_o         = (state_q != S_IDLE);
  assign protocol_err_o = err_q;

  // Access size and the address bits outside the word index carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{req_port.data_size, paddr};

endmodule
